button_event_gen: RTL and testbench

Debounces the synchronized button levels and turns them into a stream of discrete events: press, release and long-press. It sits between the two-flop button synchronizers and the UART/AXIS control logic, which consumes events over a valid/ready handshake. It replaces raw level sampling, so button glitches never reach downstream control logic.

---
 rtl/button_pkg.sv | 32 +++
 rtl/debounce_chan.sv | 96 +++++++++
 rtl/button_event_gen.sv | 109 ++++++++++
 tb/tb_button_event_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the button event generator.
// Event encoding matches the downstream consumer: PRESS=0, RELEASE=1, LONG=2.
package button_pkg;

    typedef enum logic [1:0] {
        PRESS   = 2'd0,
        RELEASE = 2'd1,
        LONG    = 2'd2
    } event_kind_e;

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } chan_state_e;

    localparam int NumKinds = 3;

    function automatic int cycles_from_ms(input int freq, input int ms);
        return freq / 1000 * ms;
    endfunction

    // Arbitration order within one button: PRESS, then LONG, then RELEASE.
    function automatic event_kind_e kind_by_rank(input int rank);
        case (rank)
            0:       return PRESS;
            1:       return LONG;
            default: return RELEASE;
        endcase
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: debounce counter, press/long/release FSM, registered event pulses.
// Latency: level flips DebounceCycles after a held change; event pulse one cycle after the flip.
// Backpressure: none; pulses are single-cycle and must be captured by the parent.
module debounce_chan
    import button_pkg::*;
#(
    parameter int DebounceCycles = 4,
    parameter int LongCycles     = 20,
    parameter int ActiveLow      = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       button_i,
    output logic       level_o,
    output logic [2:0] event_o
);

    localparam int StabW = $clog2(DebounceCycles);
    localparam int HoldW = $clog2(LongCycles);

    logic             raw;
    logic [StabW-1:0] stab_cnt;
    logic [HoldW-1:0] hold_cnt;
    logic [HoldW-1:0] hold_nxt;
    chan_state_e      state;
    chan_state_e      state_nxt;
    logic [2:0]       event_nxt;

    assign raw = button_i ^ (ActiveLow != 0);

    // Any sample that agrees with the current level restarts the window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_o  <= 1'b0;
            stab_cnt <= '0;
        end else if (raw == level_o) begin
            stab_cnt <= '0;
        end else if (stab_cnt == StabW'(DebounceCycles - 1)) begin
            level_o  <= raw;
            stab_cnt <= '0;
        end else begin
            stab_cnt <= stab_cnt + StabW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_RELEASED;
            hold_cnt <= '0;
            event_o  <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            event_o  <= event_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        event_nxt = '0;
        case (state)
            ST_RELEASED: begin
                hold_nxt = '0;
                if (level_o) begin
                    state_nxt        = ST_PRESSED;
                    event_nxt[PRESS] = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!level_o) begin
                    state_nxt          = ST_RELEASED;
                    hold_nxt           = '0;
                    event_nxt[RELEASE] = 1'b1;
                end else if (hold_cnt == HoldW'(LongCycles - 1)) begin
                    state_nxt       = ST_LONG_HELD;
                    event_nxt[LONG] = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + HoldW'(1);
                end
            end
            ST_LONG_HELD: begin
                if (!level_o) begin
                    state_nxt          = ST_RELEASED;
                    hold_nxt           = '0;
                    event_nxt[RELEASE] = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RELEASED;
                hold_nxt  = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_event_gen.sv
// Debounced button levels to a prioritised press/release/long event stream.
// Latency: 2 cycles from level_o change to event_valid_o when the output is empty.
// Backpressure: output held while !ready; repeat events merge in pending and set sticky overflow_o.
module button_event_gen
    import button_pkg::*;
#(
    parameter int NumButtons  = 3,
    parameter int ClkFreqHz   = 25000000,
    parameter int DebounceMs  = 10,
    parameter int LongPressMs = 1000,
    parameter int ActiveLow   = 0
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic [NumButtons-1:0]                          button_i,
    output logic [NumButtons-1:0]                          level_o,
    output logic                                           event_valid_o,
    input  logic                                           event_ready_i,
    output logic [$clog2(NumButtons > 1 ? NumButtons : 2)-1:0] event_btn_o,
    output logic [1:0]                                     event_kind_o,
    output logic                                           overflow_o
);

    localparam int DebounceCycles = cycles_from_ms(ClkFreqHz, DebounceMs);
    localparam int LongCycles     = cycles_from_ms(ClkFreqHz, LongPressMs);
    localparam int BtnW           = $clog2(NumButtons > 1 ? NumButtons : 2);
    localparam int NumBits        = NumButtons * NumKinds;

    logic [NumBits-1:0] pulse;
    logic [NumBits-1:0] pending;
    logic [NumBits-1:0] pending_nxt;
    logic [NumBits-1:0] eff;
    logic [NumBits-1:0] sel_oh;
    logic [NumBits-1:0] clear;
    logic               found;
    logic [BtnW-1:0]    sel_btn;
    event_kind_e        sel_kind;
    event_kind_e        out_kind;
    logic               load;
    logic               ovf_hit;

    for (genvar b = 0; b < NumButtons; b++) begin : g_chan
        debounce_chan #(
            .DebounceCycles (DebounceCycles),
            .LongCycles     (LongCycles),
            .ActiveLow      (ActiveLow)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .button_i (button_i[b]),
            .level_o  (level_o[b]),
            .event_o  (pulse[b*NumKinds +: NumKinds])
        );
    end

    // Fresh pulses are visible to the arbiter in the cycle they arrive.
    always_comb begin
        event_kind_e kk;
        eff      = pending | pulse;
        found    = 1'b0;
        sel_btn  = '0;
        sel_kind = PRESS;
        sel_oh   = '0;
        kk       = PRESS;
        for (int b = 0; b < NumButtons; b++) begin
            for (int r = 0; r < NumKinds; r++) begin
                kk = kind_by_rank(r);
                if (!found && eff[b*NumKinds + int'(kk)]) begin
                    found                         = 1'b1;
                    sel_btn                       = BtnW'(b);
                    sel_kind                      = kk;
                    sel_oh[b*NumKinds + int'(kk)] = 1'b1;
                end
            end
        end
    end

    assign load  = !event_valid_o || event_ready_i;
    assign clear = load ? sel_oh : '0;

    // A bit cleared by selection while a new pulse lands stays set, without overflow.
    assign pending_nxt = (pending & ~clear) | (pulse & ~(clear & ~pending));
    assign ovf_hit     = |(pending & pulse & ~clear);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending       <= '0;
            event_valid_o <= 1'b0;
            event_btn_o   <= '0;
            out_kind      <= PRESS;
            overflow_o    <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (ovf_hit) begin
                overflow_o <= 1'b1;
            end
            if (load) begin
                event_valid_o <= found;
                if (found) begin
                    event_btn_o <= sel_btn;
                    out_kind    <= sel_kind;
                end
            end
        end
    end

    assign event_kind_o = out_kind;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen: expected events go into a scoreboard queue,
// a negedge monitor pops and compares on every accepted handshake.
module tb_button_event_gen;
    import button_pkg::*;

    localparam int NB = 3;

    typedef struct {
        int btn;
        int kind;
        int cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] button = '0;
    logic [NB-1:0] level;
    logic          valid;
    logic          ready = 1'b1;
    logic [1:0]    btn;
    logic [1:0]    kind;
    logic          ovf;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    button_event_gen #(
        .NumButtons  (NB),
        .ClkFreqHz   (1000),
        .DebounceMs  (4),
        .LongPressMs (20),
        .ActiveLow   (0)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .button_i      (button),
        .level_o       (level),
        .event_valid_o (valid),
        .event_ready_i (ready),
        .event_btn_o   (btn),
        .event_kind_o  (kind),
        .overflow_o    (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic expect_evt(input int b, input int k, input int c);
        exp_t e;
        e.btn  = b;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_event: got btn=%0d kind=%0d at cycle %0d, required none",
                         btn, kind, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("evt_btn", int'(btn), e.btn);
                chk("evt_kind", int'(kind), e.kind);
                chk("evt_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int t0;
        int tf;
        int tr;
        int a;
        int r;

        // Reset state
        tick();
        tick();
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_btn", int'(btn), 0);
        chk("rst_kind", int'(kind), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        tick();
        tick();

        // Clean press and release on button 1
        t0 = cyc;
        button[1] = 1'b1;
        expect_evt(1, int'(PRESS), t0 + 6);
        wait_until(t0 + 3);
        chk("clean_level_before", int'(level[1]), 0);
        wait_until(t0 + 4);
        chk("clean_level_rise", int'(level), 3'b010);
        wait_until(t0 + 14);
        button[1] = 1'b0;
        expect_evt(1, int'(RELEASE), t0 + 20);
        wait_until(t0 + 22);

        // Bouncing press on button 0
        button[0] = 1'b1; tick();
        button[0] = 1'b0; tick();
        button[0] = 1'b1; tick();
        button[0] = 1'b0; tick();
        button[0] = 1'b1;
        tf = cyc;
        expect_evt(0, int'(PRESS), tf + 6);
        wait_until(tf + 3);
        chk("bounce_level_before", int'(level[0]), 0);
        wait_until(tf + 4);
        chk("bounce_level_rise", int'(level[0]), 1);
        wait_until(tf + 8);
        button[0] = 1'b0;
        tr = cyc;
        expect_evt(0, int'(RELEASE), tr + 6);
        wait_until(tr + 8);

        // Long press on button 2
        t0 = cyc;
        button[2] = 1'b1;
        expect_evt(2, int'(PRESS), t0 + 6);
        expect_evt(2, int'(LONG), t0 + 26);
        wait_until(t0 + 30);
        button[2] = 1'b0;
        expect_evt(2, int'(RELEASE), t0 + 36);
        wait_until(t0 + 38);

        // Simultaneous press of 0 and 2 while stalled
        t0 = cyc;
        ready = 1'b0;
        button[0] = 1'b1;
        button[2] = 1'b1;
        for (int i = 7; i <= 11; i++) begin
            wait_until(t0 + i);
            chk("stall_valid", int'(valid), 1);
            chk("stall_btn", int'(btn), 0);
            chk("stall_kind", int'(kind), int'(PRESS));
        end
        wait_until(t0 + 12);
        ready = 1'b1;
        expect_evt(0, int'(PRESS), t0 + 12);
        expect_evt(2, int'(PRESS), t0 + 13);
        wait_until(t0 + 14);
        button[0] = 1'b0;
        button[2] = 1'b0;
        tr = cyc;
        expect_evt(0, int'(RELEASE), tr + 6);
        expect_evt(2, int'(RELEASE), tr + 7);
        wait_until(tr + 9);

        // Overflow: output occupied, button 1 pressed/released twice
        t0 = cyc;
        ready = 1'b0;
        button[0] = 1'b1;
        wait_until(t0 + 8);
        a = cyc;
        button[1] = 1'b1;
        wait_until(a + 6);
        button[1] = 1'b0;
        wait_until(a + 10);
        chk("ovf_clear", int'(ovf), 0);
        wait_until(a + 12);
        button[1] = 1'b1;
        wait_until(a + 18);
        button[1] = 1'b0;
        wait_until(a + 26);
        chk("ovf_set", int'(ovf), 1);
        wait_until(a + 28);
        ready = 1'b1;
        r = cyc;
        expect_evt(0, int'(PRESS), r);
        expect_evt(0, int'(LONG), r + 1);
        expect_evt(1, int'(PRESS), r + 2);
        expect_evt(1, int'(RELEASE), r + 3);
        wait_until(r + 5);
        chk("ovf_sticky", int'(ovf), 1);
        button[0] = 1'b0;
        expect_evt(0, int'(RELEASE), r + 11);
        wait_until(r + 13);

        // Reset mid-hold on button 2
        t0 = cyc;
        button[2] = 1'b1;
        expect_evt(2, int'(PRESS), t0 + 6);
        wait_until(t0 + 15);
        rst_n = 1'b0;
        #1;
        chk("midrst_level", int'(level), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_btn", int'(btn), 0);
        chk("midrst_kind", int'(kind), 0);
        chk("midrst_ovf", int'(ovf), 0);
        tick();
        tick();
        rst_n = 1'b1;
        r = cyc;
        expect_evt(2, int'(PRESS), r + 6);
        wait_until(r + 3);
        chk("postrst_level_before", int'(level[2]), 0);
        wait_until(r + 4);
        chk("postrst_level_rise", int'(level[2]), 1);
        wait_until(r + 10);
        button[2] = 1'b0;
        expect_evt(2, int'(RELEASE), r + 16);
        wait_until(r + 22);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
